// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-bus target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_BYTE   = 3'd1,
    ST_TX_ACK    = 3'd2,
    ST_TX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_WAIT_STOP = 3'd5
  } i2c_tgt_state_t;

  localparam logic [6:0]  SGTL5000_DEV_ADDR = 7'h0A;
  localparam int          I2C_WORD_BYTES    = 2;
  localparam logic [15:0] ADDR_STEP         = 16'(I2C_WORD_BYTES);

  localparam logic [2:0] BYTE_DEV   = 3'd0;
  localparam logic [2:0] BYTE_RA_HI = 3'd1;
  localparam logic [2:0] BYTE_RA_LO = 3'd2;
  localparam logic [2:0] BYTE_D_HI  = 3'd3;
  localparam logic [2:0] BYTE_D_LO  = 3'd4;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and produces registered edge, START and STOP pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_lvl
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_d_r;
  logic                   sda_d_r;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  // Synchronizer chains, delayed copies and registered condition pulses; bus idles high.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_r <= '1;
      sda_sync_r <= '1;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      sda_lvl    <= 1'b1;
    end else begin
      scl_sync_r[0] <= scl_in;
      sda_sync_r[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_r[i] <= scl_sync_r[i-1];
        sda_sync_r[i] <= sda_sync_r[i-1];
      end
      scl_d_r   <= scl_s;
      sda_d_r   <= sda_s;
      scl_rise  <= scl_s & ~scl_d_r;
      scl_fall  <= ~scl_s & scl_d_r;
      start_det <= scl_s & scl_d_r & sda_d_r & ~sda_s;
      stop_det  <= scl_s & scl_d_r & ~sda_d_r & sda_s;
      sda_lvl   <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target decoding 16-bit-address / 16-bit-data register transactions
// into a parallel register bus with write and read strobes.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = SGTL5000_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  logic scl_rise_s, scl_fall_s, start_s, stop_s, sda_lvl_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk50     (clk50),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_s),
    .stop_det  (stop_s),
    .sda_lvl   (sda_lvl_s)
  );

  i2c_tgt_state_t state_r, state_nxt;
  logic [3:0]  bit_cnt_r, bit_cnt_nxt;
  logic [2:0]  byte_idx_r, byte_idx_nxt;
  logic [7:0]  shift_r, shift_nxt;
  logic [7:0]  tx_lo_r, tx_lo_nxt;
  logic [7:0]  addr_hi_r, addr_hi_nxt;
  logic [7:0]  data_hi_r, data_hi_nxt;
  logic        rw_r, rw_nxt;
  logic        wr_pend_r, wr_pend_nxt;
  logic        ack_seen_r, ack_seen_nxt;
  logic        tx_lo_phase_r, tx_lo_phase_nxt;
  logic        sda_oe_r, sda_oe_nxt;
  logic [15:0] reg_addr_r, reg_addr_nxt;
  logic [15:0] reg_wdata_r, reg_wdata_nxt;
  logic        reg_wr_r, reg_wr_nxt;
  logic        reg_rd_r, reg_rd_nxt;
  logic        busy_r, busy_nxt;
  logic [7:0]  rx_byte_s;

  assign rx_byte_s = {shift_r[6:0], sda_lvl_s};

  // Next-state and next-output decode; START/STOP take priority over SCL edges.
  always_comb begin
    state_nxt       = state_r;
    bit_cnt_nxt     = bit_cnt_r;
    byte_idx_nxt    = byte_idx_r;
    shift_nxt       = shift_r;
    tx_lo_nxt       = tx_lo_r;
    addr_hi_nxt     = addr_hi_r;
    data_hi_nxt     = data_hi_r;
    rw_nxt          = rw_r;
    wr_pend_nxt     = wr_pend_r;
    ack_seen_nxt    = ack_seen_r;
    tx_lo_phase_nxt = tx_lo_phase_r;
    sda_oe_nxt      = sda_oe_r;
    reg_addr_nxt    = reg_addr_r;
    reg_wdata_nxt   = reg_wdata_r;
    reg_wr_nxt      = 1'b0;
    reg_rd_nxt      = 1'b0;
    if (start_s) begin
      state_nxt    = ST_RX_BYTE;
      byte_idx_nxt = BYTE_DEV;
      bit_cnt_nxt  = 4'd0;
      rw_nxt       = 1'b0;
      wr_pend_nxt  = 1'b0;
      sda_oe_nxt   = 1'b0;
    end else if (stop_s) begin
      state_nxt  = ST_IDLE;
      sda_oe_nxt = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RX_BYTE: begin
          if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
            shift_nxt   = rx_byte_s;
            bit_cnt_nxt = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              case (byte_idx_r)
                BYTE_DEV: begin
                  if (rx_byte_s[7:1] == DEV_ADDR) begin
                    rw_nxt       = rx_byte_s[0];
                    reg_rd_nxt   = rx_byte_s[0];
                    byte_idx_nxt = BYTE_RA_HI;
                  end else begin
                    state_nxt = ST_WAIT_STOP;
                  end
                end
                BYTE_RA_HI: begin
                  addr_hi_nxt  = rx_byte_s;
                  byte_idx_nxt = BYTE_RA_LO;
                end
                BYTE_RA_LO: begin
                  reg_addr_nxt = {addr_hi_r, rx_byte_s};
                  wr_pend_nxt  = 1'b0;
                  byte_idx_nxt = BYTE_D_HI;
                end
                BYTE_D_HI: begin
                  data_hi_nxt  = rx_byte_s;
                  byte_idx_nxt = BYTE_D_LO;
                end
                BYTE_D_LO: begin
                  // The first word of a burst lands on the received address; later words step.
                  reg_wdata_nxt = {data_hi_r, rx_byte_s};
                  reg_wr_nxt    = 1'b1;
                  reg_addr_nxt  = wr_pend_r ? (reg_addr_r + ADDR_STEP) : reg_addr_r;
                  wr_pend_nxt   = 1'b1;
                  byte_idx_nxt  = BYTE_D_HI;
                end
                default: state_nxt = ST_WAIT_STOP;
              endcase
            end else begin
              byte_idx_nxt = byte_idx_r;
            end
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            state_nxt  = ST_TX_ACK;
            sda_oe_nxt = 1'b1;
          end else begin
            state_nxt = ST_RX_BYTE;
          end
        end
        ST_TX_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_nxt = 4'd0;
            if (rw_r) begin
              state_nxt       = ST_TX_BYTE;
              shift_nxt       = reg_rdata[15:8];
              tx_lo_nxt       = reg_rdata[7:0];
              tx_lo_phase_nxt = 1'b0;
              sda_oe_nxt      = ~reg_rdata[15];
            end else begin
              state_nxt  = ST_RX_BYTE;
              sda_oe_nxt = 1'b0;
            end
          end else begin
            state_nxt = ST_TX_ACK;
          end
        end
        ST_TX_BYTE: begin
          if (scl_rise_s) begin
            bit_cnt_nxt = bit_cnt_r + 4'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
              state_nxt    = ST_RX_ACK;
              sda_oe_nxt   = 1'b0;
              ack_seen_nxt = 1'b0;
            end else begin
              shift_nxt  = {shift_r[6:0], 1'b0};
              sda_oe_nxt = ~shift_r[6];
            end
          end else begin
            state_nxt = ST_TX_BYTE;
          end
        end
        ST_RX_ACK: begin
          if (scl_rise_s) begin
            ack_seen_nxt = 1'b1;
            if (sda_lvl_s) begin
              state_nxt = ST_WAIT_STOP;
            end else if (tx_lo_phase_r) begin
              reg_addr_nxt = reg_addr_r + ADDR_STEP;
              reg_rd_nxt   = 1'b1;
            end else begin
              state_nxt = ST_RX_ACK;
            end
          end else if (scl_fall_s && ack_seen_r) begin
            state_nxt   = ST_TX_BYTE;
            bit_cnt_nxt = 4'd0;
            if (tx_lo_phase_r) begin
              shift_nxt       = reg_rdata[15:8];
              tx_lo_nxt       = reg_rdata[7:0];
              sda_oe_nxt      = ~reg_rdata[15];
              tx_lo_phase_nxt = 1'b0;
            end else begin
              shift_nxt       = tx_lo_r;
              sda_oe_nxt      = ~tx_lo_r[7];
              tx_lo_phase_nxt = 1'b1;
            end
          end else begin
            state_nxt = ST_RX_ACK;
          end
        end
        ST_WAIT_STOP: state_nxt = ST_WAIT_STOP;
        default: begin
          state_nxt  = ST_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers; reset releases SDA asynchronously.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 4'd0;
      byte_idx_r    <= BYTE_DEV;
      shift_r       <= 8'h00;
      tx_lo_r       <= 8'h00;
      addr_hi_r     <= 8'h00;
      data_hi_r     <= 8'h00;
      rw_r          <= 1'b0;
      wr_pend_r     <= 1'b0;
      ack_seen_r    <= 1'b0;
      tx_lo_phase_r <= 1'b0;
      sda_oe_r      <= 1'b0;
      reg_addr_r    <= 16'h0000;
      reg_wdata_r   <= 16'h0000;
      reg_wr_r      <= 1'b0;
      reg_rd_r      <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      bit_cnt_r     <= bit_cnt_nxt;
      byte_idx_r    <= byte_idx_nxt;
      shift_r       <= shift_nxt;
      tx_lo_r       <= tx_lo_nxt;
      addr_hi_r     <= addr_hi_nxt;
      data_hi_r     <= data_hi_nxt;
      rw_r          <= rw_nxt;
      wr_pend_r     <= wr_pend_nxt;
      ack_seen_r    <= ack_seen_nxt;
      tx_lo_phase_r <= tx_lo_phase_nxt;
      sda_oe_r      <= sda_oe_nxt;
      reg_addr_r    <= reg_addr_nxt;
      reg_wdata_r   <= reg_wdata_nxt;
      reg_wr_r      <= reg_wr_nxt;
      reg_rd_r      <= reg_rd_nxt;
      busy_r        <= busy_nxt;
    end
  end

  assign sda_oe    = sda_oe_r;
  assign reg_addr  = reg_addr_r;
  assign reg_wdata = reg_wdata_r;
  assign reg_wr    = reg_wr_r;
  assign reg_rd    = reg_rd_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench: an I2C controller model drives table-driven write
// transactions plus hand-written read and reset-abort sequences.
module tb_i2c_target_regs;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        scl_ctrl;
  logic        sda_ctrl;
  logic        sda_oe;
  logic [15:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        busy;
  wire         sda_bus = sda_ctrl & ~sda_oe;

  always #10 clk50 = ~clk50;

  i2c_target_regs dut (
    .clk50     (clk50),
    .reset_n   (reset_n),
    .scl_in    (scl_ctrl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] rd_addr_q[$];
  bit          oe_seen;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk50) begin
    if (reg_wr) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
    end
    if (reg_rd) rd_addr_q.push_back(reg_addr);
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    oe_seen = 1'b0;
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    wait_clk(10); sda_ctrl = b;
    wait_clk(10); scl_ctrl = 1'b1;
    wait_clk(10); s = sda_bus;
    wait_clk(10); scl_ctrl = 1'b0;
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; wait_clk(10);
    scl_ctrl = 1'b1; wait_clk(10);
    sda_ctrl = 1'b0; wait_clk(10);
    scl_ctrl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(10); sda_ctrl = 1'b0;
    wait_clk(10); scl_ctrl = 1'b1;
    wait_clk(10); sda_ctrl = 1'b1;
    wait_clk(20);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(~ack, s);
  endtask

  typedef struct {
    logic [55:0] data;
    int          nbytes;
    int          exp_acks;
    int          exp_wr;
    logic [15:0] a0, d0, a1, d1;
    logic        exp_oe;
  } wvec_t;

  wvec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ack;
    logic [7:0]  rb0, rb1;
    int          acks;
    logic [31:0] got;

    vecs[0] = '{56'h14_00_30_40_60_00_00, 5, 5, 1, 16'h0030, 16'h4060, 16'h0000, 16'h0000, 1'b1};
    vecs[1] = '{56'h16_00_30_40_60_00_00, 5, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{56'h14_00_30_11_22_33_44, 7, 7, 2, 16'h0030, 16'h1122, 16'h0032, 16'h3344, 1'b1};
    vecs[3] = '{56'h14_FF_FE_AA_BB_CC_DD, 7, 7, 2, 16'hFFFE, 16'hAABB, 16'h0000, 16'hCCDD, 1'b1};
    vecs[4] = '{56'h14_00_30_40_00_00_00, 4, 4, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};

    reg_rdata = 16'hA011;
    scl_ctrl  = 1'b1;
    sda_ctrl  = 1'b1;
    reset_n   = 1'b0;
    wait_clk(5);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    check("rst_reg_rd", {31'd0, reg_rd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_reg_addr", {16'd0, reg_addr}, 32'd0);
    check("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
    reset_n = 1'b1;
    wait_clk(10);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      i2c_start();
      acks = 0;
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        send_byte(vecs[v].data[55-8*k -: 8], ack);
        if (ack) acks++;
        if (k == 0) check($sformatf("v%0d_busy_mid", v), {31'd0, busy}, 32'd1);
      end
      i2c_stop();
      check($sformatf("v%0d_acks", v), acks, vecs[v].exp_acks);
      check($sformatf("v%0d_wr_count", v), wr_addr_q.size(), vecs[v].exp_wr);
      check($sformatf("v%0d_rd_count", v), rd_addr_q.size(), 32'd0);
      check($sformatf("v%0d_oe_seen", v), {31'd0, oe_seen}, {31'd0, vecs[v].exp_oe});
      check($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
      for (int j = 0; j < vecs[v].exp_wr; j++) begin
        got = (j < wr_addr_q.size()) ? {16'd0, wr_addr_q[j]} : 32'hDEAD_BEEF;
        check($sformatf("v%0d_wr%0d_addr", v, j), got, {16'd0, (j == 0) ? vecs[v].a0 : vecs[v].a1});
        got = (j < wr_data_q.size()) ? {16'd0, wr_data_q[j]} : 32'hDEAD_BEEF;
        check($sformatf("v%0d_wr%0d_data", v, j), got, {16'd0, (j == 0) ? vecs[v].d0 : vecs[v].d1});
      end
    end

    // Register-address write, repeated START, two-byte read ending in NACK.
    clear_mon();
    i2c_start();
    acks = 0;
    send_byte(8'h14, ack); if (ack) acks++;
    send_byte(8'h00, ack); if (ack) acks++;
    send_byte(8'h02, ack); if (ack) acks++;
    i2c_start();
    send_byte(8'h15, ack); if (ack) acks++;
    recv_byte(1'b1, rb0);
    recv_byte(1'b0, rb1);
    check("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    check("rd_acks", acks, 32'd4);
    check("rd_byte_hi", {24'd0, rb0}, 32'h0000_00A0);
    check("rd_byte_lo", {24'd0, rb1}, 32'h0000_0011);
    check("rd_count", rd_addr_q.size(), 32'd1);
    got = (rd_addr_q.size() > 0) ? {16'd0, rd_addr_q[0]} : 32'hDEAD_BEEF;
    check("rd_addr", got, 32'h0000_0002);
    check("rd_wr_count", wr_addr_q.size(), 32'd0);
    check("rd_busy_end", {31'd0, busy}, 32'd0);

    // Reset asserted while the target drives the address ACK.
    clear_mon();
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic s;
      bit_cycle(((8'h14 >> i) & 8'h01) != 8'h00, s);
    end
    wait_clk(10);
    check("abort_ack_driven", {31'd0, sda_oe}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_oe_released", {31'd0, sda_oe}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    wait_clk(3);
    reset_n = 1'b1;
    i2c_stop();
    check("abort_wr_count", wr_addr_q.size(), 32'd0);
    check("abort_rd_count", rd_addr_q.size(), 32'd0);
    check("abort_busy_end", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
